// File: rtl/bcd_stopwatch_ctrl_pkg.sv
// Shared types and constants for the BCD stopwatch controller and its digit cells.
// The load sanitiser lives here so the rule for out-of-range digits is stated once.
package bcd_stopwatch_ctrl_pkg;

   localparam int DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

   typedef logic [DIGIT_W-1:0] digit_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   // Non-decimal nibbles load as zero so the counter never holds an illegal digit.
   function automatic digit_t bcd_sanitize(input digit_t d);
      return (d > BCD_MAX) ? '0 : d;
   endfunction

endpackage

// File: rtl/bcd_stopwatch_ctrl_digit.sv
// One BCD digit register: clear > load > increment, 9 wraps to 0.
// Single register stage; no backpressure, the enables are applied at the edge they are seen.
module bcd_digit
   import bcd_stopwatch_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               clr,
   input  logic               ld,
   input  logic [DIGIT_W-1:0] ld_data,
   input  logic               inc,
   output logic [DIGIT_W-1:0] q
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (ld) begin
         q <= bcd_sanitize(ld_data);
      end else if (inc) begin
         q <= (q == BCD_MAX) ? '0 : q + 4'd1;
      end
   end

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Stopwatch control FSM (IDLE/RUN/HALT) driving an NDIG-digit cascaded BCD counter.
// Counted ticks land in COUNT at the same edge; inputs are levels with fixed priority, no backpressure.
module bcd_stopwatch_ctrl
   import bcd_stopwatch_ctrl_pkg::*;
#(
   parameter int NDIG = 4
)(
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    clear,
   input  logic                    load,
   input  logic [DIGIT_W*NDIG-1:0] data,
   input  logic                    tick,
   output logic [DIGIT_W*NDIG-1:0] count,
   output logic                    running,
   output logic                    ovf,
   output logic [NDIG-1:0]         digit_inc
);

   state_t          state;
   state_t          state_nxt;
   logic            ld_acc;
   logic            cnt_en;
   logic [NDIG:0]   carry;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         running <= 1'b0;
      end else begin
         state   <= state_nxt;
         running <= (state_nxt == RUN);
      end
   end

   // Only the highest-priority active input acts; a LOAD seen in RUN still masks the lower ones.
   always_comb begin
      state_nxt = state;
      if (clear) begin
         state_nxt = IDLE;
      end else if (load) begin
         state_nxt = state;
      end else if (stop) begin
         if (state == RUN) state_nxt = HALT;
      end else if (start) begin
         if (state != RUN) state_nxt = RUN;
      end
   end

   always_comb begin
      ld_acc = 1'b0;
      cnt_en = 1'b0;
      if (!clear && load && (state != RUN)) ld_acc = 1'b1;
      if ((state == RUN) && tick && !clear && !load && !stop && !start) cnt_en = 1'b1;
   end

   assign carry[0]  = cnt_en;
   assign digit_inc = carry[NDIG-1:0];

   for (genvar i = 0; i < NDIG; i++) begin : g_dig
      assign carry[i+1] = carry[i] && (count[i*DIGIT_W +: DIGIT_W] == BCD_MAX);

      bcd_digit u_digit (
         .clk     (clk),
         .reset_n (reset_n),
         .clr     (clear),
         .ld      (ld_acc),
         .ld_data (data[i*DIGIT_W +: DIGIT_W]),
         .inc     (carry[i]),
         .q       (count[i*DIGIT_W +: DIGIT_W])
      );
   end

   // Carry out of the top digit means every digit was 9: the counter just wrapped.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ovf <= 1'b0;
      end else if (clear || ld_acc) begin
         ovf <= 1'b0;
      end else if (carry[NDIG]) begin
         ovf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// Bench for bcd_stopwatch_ctrl: integer-valued reference model compared every falling edge,
// plus directed scenarios with literal expectations and a randomized soak.
module tb_bcd_stopwatch_ctrl;

   localparam int NDIG = 4;
   localparam int W    = 4 * NDIG;
   localparam int S_IDLE = 0;
   localparam int S_RUN  = 1;
   localparam int S_HALT = 2;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0, stop = 1'b0, clear = 1'b0, load = 1'b0, tick = 1'b0;
   logic [W-1:0]  data = '0;
   logic [W-1:0]  count;
   logic          running;
   logic          ovf;
   logic [NDIG-1:0] digit_inc;

   int checks = 0;
   int failures = 0;

   int m_val;
   bit m_ovf;
   int m_st;

   bcd_stopwatch_ctrl #(.NDIG(NDIG)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .clear(clear),
      .load(load), .data(data), .tick(tick), .count(count), .running(running),
      .ovf(ovf), .digit_inc(digit_inc)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic int pow10(input int n);
      int r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r = '0;
      for (int i = 0; i < NDIG; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
      return r;
   endfunction

   function automatic int from_data(input logic [W-1:0] d);
      int v = 0;
      for (int i = 0; i < NDIG; i++) begin
         int dg;
         dg = int'(d[4*i +: 4]);
         if (dg > 9) dg = 0;
         v = v + dg * pow10(i);
      end
      return v;
   endfunction

   function automatic bit counted();
      return (m_st == S_RUN) && tick && !clear && !load && !stop && !start;
   endfunction

   // A counted tick touches digit 0 plus every digit above a run of trailing nines.
   function automatic logic [NDIG-1:0] exp_inc();
      logic [NDIG-1:0] r = '0;
      int v;
      if (!counted()) return r;
      v = m_val;
      for (int i = 0; i < NDIG; i++) begin
         r[i] = 1'b1;
         if (v % 10 != 9) break;
         v = v / 10;
      end
      return r;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_val = 0; m_ovf = 0; m_st = S_IDLE;
      end else if (clear) begin
         m_val = 0; m_ovf = 0; m_st = S_IDLE;
      end else if (load) begin
         if (m_st != S_RUN) begin
            m_val = from_data(data); m_ovf = 0;
         end
      end else if (stop) begin
         if (m_st == S_RUN) m_st = S_HALT;
      end else if (start) begin
         m_st = S_RUN;
      end else if (m_st == S_RUN && tick) begin
         m_val = m_val + 1;
         if (m_val == pow10(NDIG)) begin
            m_val = 0; m_ovf = 1;
         end
      end
   end

   always @(negedge clk) begin
      check("model_count",     32'(count),     32'(to_bcd(m_val)));
      check("model_running",   32'(running),   32'(m_st == S_RUN));
      check("model_ovf",       32'(ovf),       32'(m_ovf));
      check("model_digit_inc", 32'(digit_inc), 32'(exp_inc()));
   end

   task automatic cyc(input logic st, input logic sp, input logic cl, input logic ld,
                      input logic tk, input logic [W-1:0] d);
      start = st; stop = sp; clear = cl; load = ld; tick = tk; data = d;
      @(posedge clk); #1;
   endtask

   initial begin
      #6;
      check("reset_count",   32'(count),   32'h0);
      check("reset_running", 32'(running), 32'h0);
      check("reset_ovf",     32'(ovf),     32'h0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // Start, then twelve ticks; the tenth sees 0009 and carries into digit 1.
      cyc(1, 0, 0, 0, 0, '0);
      for (int i = 1; i <= 12; i++) begin
         start = 0; stop = 0; clear = 0; load = 0; tick = 1;
         if (i == 10) begin
            #2;
            check("tick10_digit_inc", 32'(digit_inc), 32'h3);
         end
         @(posedge clk); #1;
      end
      check("twelve_count",   32'(count),   32'h0012);
      check("twelve_running", 32'(running), 32'h1);
      check("twelve_ovf",     32'(ovf),     32'h0);

      // Wrap through 9999.
      cyc(0, 1, 0, 0, 0, '0);
      cyc(0, 0, 0, 1, 0, 16'h9998);
      cyc(1, 0, 0, 0, 0, '0);
      cyc(0, 0, 0, 0, 1, '0);
      check("wrap_9999", 32'(count), 32'h9999);
      check("wrap_9999_ovf", 32'(ovf), 32'h0);
      cyc(0, 0, 0, 0, 1, '0);
      check("wrap_0000", 32'(count), 32'h0000);
      check("wrap_ovf_set", 32'(ovf), 32'h1);
      cyc(0, 0, 0, 0, 1, '0);
      check("wrap_0001", 32'(count), 32'h0001);
      check("wrap_ovf_sticky", 32'(ovf), 32'h1);

      // Load ignored in RUN; accepted in HALT with illegal digit zeroed.
      cyc(0, 0, 0, 1, 0, 16'h1234);
      check("load_in_run", 32'(count), 32'h0001);
      cyc(0, 1, 0, 0, 0, '0);
      cyc(0, 0, 0, 1, 0, 16'h12A4);
      check("load_sanitize", 32'(count), 32'h1204);
      check("load_clr_ovf", 32'(ovf), 32'h0);

      // START+STOP in RUN halts; ticks in HALT hold; CLEAR beats LOAD.
      cyc(1, 0, 0, 0, 0, '0);
      check("restart_running", 32'(running), 32'h1);
      cyc(1, 1, 0, 0, 0, '0);
      check("startstop_running", 32'(running), 32'h0);
      cyc(0, 0, 0, 0, 1, '0);
      cyc(0, 0, 0, 0, 1, '0);
      cyc(0, 0, 0, 0, 1, '0);
      check("halt_hold", 32'(count), 32'h1204);
      cyc(0, 0, 1, 1, 0, 16'h5555);
      check("clear_load_count", 32'(count), 32'h0000);
      check("clear_load_running", 32'(running), 32'h0);

      // Asynchronous reset between edges while running at 0457.
      cyc(0, 0, 0, 1, 0, 16'h0457);
      cyc(1, 0, 0, 0, 0, '0);
      check("pre_reset_count", 32'(count), 32'h0457);
      start = 0; tick = 0;
      reset_n = 1'b0;
      #1;
      check("async_reset_count", 32'(count), 32'h0000);
      check("async_reset_running", 32'(running), 32'h0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, '0);
      check("post_reset_no_count", 32'(count), 32'h0000);
      check("post_reset_idle", 32'(running), 32'h0);

      // Randomized soak against the model.
      for (int n = 0; n < 4000; n++) begin
         logic [W-1:0] d;
         d = 16'($urandom);
         if ($urandom_range(0, 3) == 0) d = {12'h999, d[3:0]};
         if ($urandom_range(0, 199) == 0) begin
            reset_n = 1'b0;
            #2;
            reset_n = 1'b1;
         end
         cyc($urandom_range(0, 99) < 10, $urandom_range(0, 99) < 6,
             $urandom_range(0, 99) < 2,  $urandom_range(0, 99) < 8,
             $urandom_range(0, 99) < 70, d);
      end

      @(negedge clk); #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bcd_stopwatch_ctrl.md
BCD_STOPWATCH_CTRL -- requirements
Module: bcd_stopwatch_ctrl

Interface
REQ-001 SHALL have parameter NDIG, default 4: number of cascaded BCD digits (supported 1..8).
REQ-002 SHALL have port CLK  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port RESET_N  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port START  input  1  level sampled per edge; request to enter RUN.
REQ-005 SHALL have port STOP  input  1  level sampled per edge; request to leave RUN.
REQ-006 SHALL have port CLEAR  input  1  synchronous clear of all digits and flags.
REQ-007 SHALL have port LOAD  input  1  preset request.
REQ-008 SHALL have port DATA  input  4*NDIG  preset value; digit i in bits [4i+3:4i], digit 0 least significant.
REQ-009 SHALL have port TICK  input  1  count strobe; one increment per edge at which it is high.
REQ-010 SHALL have port COUNT  output  4*NDIG  current BCD value, registered.
REQ-011 SHALL have port RUNNING  output  1  high while state is RUN.
REQ-012 SHALL have port OVF  output  1  sticky wrap flag.
REQ-013 SHALL have port DIGIT_INC  output  NDIG  per-digit increment enables applied at the current edge (combinational, observability).

Function
REQ-014 SHALL implement states IDLE, RUN, HALT; state encoding internal.
REQ-015 SHALL apply per-edge priority: CLEAR > LOAD > STOP > START > TICK.
REQ-016 CLEAR SHALL, in any state, set COUNT to all zeros, OVF to 0, state to IDLE at the same edge.
REQ-017 LOAD SHALL be accepted only in IDLE or HALT: COUNT <= DATA and OVF <= 0 at that edge, state unchanged; in RUN, LOAD SHALL be ignored.
REQ-018 A DATA digit greater than 9 SHALL be loaded as 0; other digits load unchanged.
REQ-019 STOP in RUN SHALL move to HALT; STOP in IDLE or HALT SHALL have no effect.
REQ-020 START in IDLE or HALT SHALL move to RUN; with START and STOP both high, STOP wins (RUN->HALT, others unchanged).
REQ-021 TICK SHALL be counted only when the current (pre-edge) state is RUN and no higher-priority input is active; TICK on the edge entering RUN is not counted.
REQ-022 Latency: COUNT SHALL reflect a counted TICK at the same rising edge (one register stage, no extra delay).
REQ-023 DIGIT_INC[0] SHALL equal the counted-TICK condition; DIGIT_INC[k] SHALL equal DIGIT_INC[k-1] AND digit k-1 == 9.
REQ-024 A digit with DIGIT_INC high SHALL go 9->0, otherwise +1; digits with DIGIT_INC low hold.
REQ-025 When all digits are 9 and a TICK is counted, COUNT SHALL wrap to all zeros and OVF SHALL set; OVF stays 1 until CLEAR, LOAD or reset; counting continues in RUN.
REQ-026 RUNNING SHALL be a registered decode of state RUN.

Reset
REQ-027 RESET_N low SHALL immediately force state IDLE, COUNT all zeros, OVF 0, RUNNING 0, independent of CLK.
REQ-028 Reset asserted mid-count SHALL discard the value; after release the block SHALL count only after a new START.
REQ-029 The first rising edge after RESET_N deasserts SHALL process inputs normally.

Structure
REQ-030 Shared package SHALL hold the state enumeration (IDLE, RUN, HALT), BCD_MAX = 9 and digit width 4.
REQ-031 A sub-module bcd_digit (4-bit, inputs CLK, RESET_N, CLR, LD, LD_DATA, INC; output Q) SHALL be instantiated NDIG times via generate; cascade and FSM logic live in the top.

Verification
REQ-032 Reset, START, 12 TICKs (NDIG=4) -> COUNT 0012, RUNNING 1, OVF 0; DIGIT_INC 0011 on the 10th tick.
REQ-033 HALT, LOAD DATA=0x9998, START, 3 TICKs -> 9999, then 0000 with OVF 1, then 0001; OVF still 1.
REQ-034 LOAD DATA=0x1234 while RUN -> ignored; after STOP, LOAD 0x12A4 -> COUNT 1204, OVF 0.
REQ-035 START+STOP same edge in RUN -> HALT; TICK held high in HALT -> COUNT unchanged; CLEAR+LOAD same edge -> 0000, IDLE.
REQ-036 RESET_N pulled low between edges at COUNT 0457 -> COUNT 0000, RUNNING 0 before next edge; TICKs after release without START -> no change.
